multi_shift_register: RTL

MULTI_SHIFT_REGISTER -- requirements
Module: multi_shift_register

---
 rtl/multi_shift_pkg.sv | 16 +
 rtl/shift_step.sv | 26 ++
 rtl/multi_shift_register.sv | 110 +++++++++++
 3 files changed

// File: rtl/multi_shift_pkg.sv
// Shared encodings for the multi-cycle shift register.
package multi_shift_pkg;

  typedef enum logic [1:0] {
    MODE_ASR = 2'b00,
    MODE_LSR = 2'b01,
    MODE_LSL = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of up to STEP_MAX positions.
module shift_step
  import multi_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned StepW = 4
) (
  input  logic [WIDTH-1:0] value_i,
  input  shift_mode_e      mode_i,
  input  logic [StepW-1:0] step_i,
  output logic [WIDTH-1:0] result_o
);

  // Right shifts go through a double-width vector so a step equal to WIDTH is well defined.
  always_comb begin
    result_o = value_i;
    unique case (mode_i)
      MODE_ASR: result_o = WIDTH'({{WIDTH{value_i[WIDTH-1]}}, value_i} >> step_i);
      MODE_LSR: result_o = WIDTH'({{WIDTH{1'b0}}, value_i} >> step_i);
      MODE_LSL: result_o = value_i << step_i;
      MODE_ROR: result_o = WIDTH'({value_i, value_i} >> step_i);
      default:  result_o = value_i;
    endcase
  end

endmodule

// File: rtl/multi_shift_register.sv
// Shift register that applies a long shift as a series of bounded steps, one per clock.
module multi_shift_register
  import multi_shift_pkg::*;
#(
  parameter int unsigned WIDTH    = 17,
  parameter int unsigned AMT_W    = 5,
  parameter int unsigned STEP_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned StepW = $clog2(STEP_MAX + 1);

  state_e           state_q, state_d;
  shift_mode_e      mode_q, mode_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             done_q, done_d;

  logic [31:0]      rem_ext, step_ext;
  logic [StepW-1:0] step;
  logic             last_step;
  logic [WIDTH-1:0] step_result;

  // Step size is the remaining distance clamped to STEP_MAX.
  always_comb begin
    rem_ext = 32'(rem_q);
    if (rem_ext > STEP_MAX) begin
      step_ext = STEP_MAX;
    end else begin
      step_ext = rem_ext;
    end
    step      = StepW'(step_ext);
    last_step = (rem_ext <= STEP_MAX);
  end

  shift_step #(
    .WIDTH(WIDTH),
    .StepW(StepW)
  ) u_shift_step (
    .value_i (reg_q),
    .mode_i  (mode_q),
    .step_i  (step),
    .result_o(step_result)
  );

  // Next-state logic: load wins over everything, start only accepted when idle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    reg_d   = reg_q;
    done_d  = 1'b0;
    if (load) begin
      reg_d   = data;
      rem_d   = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StShift;
            rem_d   = amount;
            mode_d  = shift_mode_e'(mode);
          end
        end
        StShift: begin
          reg_d = step_result;
          rem_d = rem_q - AMT_W'(step_ext);
          if (last_step) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= MODE_ASR;
      rem_q   <= '0;
      reg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      reg_q   <= reg_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == StShift);
  assign done     = done_q;
  assign out_data = reg_q;

endmodule
